// File: rtl/des_pkg.sv
// des_pkg: shared constants for the DES round controller and its keygen.
//   - Round count and the key_cnt select range (2..17 active, 0 idle).
//   - Controller state encoding.
//   - Key-schedule tables (PC-1, PC-2) with 1-based, MSB-first bit numbering.
//   - Cumulative C/D left-rotation per round.
package des_pkg;

  localparam int NUM_ROUNDS = 16;

  localparam logic [4:0] KCNT_FIRST = 5'd2;
  localparam logic [4:0] KCNT_LAST  = 5'd17;
  localparam logic [4:0] KCNT_IDLE  = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Total rotation applied to C and D by the end of round 1..16. Storing the
  // running sum lets any round key be formed directly, without iterating.
  localparam logic [4:0] ROT_AMT [16] = '{
    5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
    5'd15, 5'd17, 5'd19, 5'd21, 5'd23, 5'd25, 5'd27, 5'd28
  };

  // 28-bit rotate left by 0..28; a rotation of 28 returns x unchanged.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] dbl;
    dbl = {x, x} << n;
    return dbl[55:28];
  endfunction

endpackage

// File: rtl/des_round_ctrl_keygen.sv
// des_round_ctrl_keygen: combinational DES round-key generator.
//   key       in  64  DES key incl. parity bits (bit 63 = DES bit 1)
//   key_cnt   in  5   round select; 2..17 gives round keys K1..K16
//   round_key out 48  selected round key, 0 for any other select
module des_round_ctrl_keygen
  import des_pkg::*;
(
  input  logic [63:0] key,
  input  logic [4:0]  key_cnt,
  output logic [47:0] round_key
);

  logic [55:0] cd_base;
  logic [55:0] cd_rot;
  logic [47:0] pc2_out;
  logic [4:0]  rot_amt;
  logic        sel_valid;
  logic        keygen_unused;

  // PC-1: drop the parity bits and split into C (55:28) / D (27:0).
  for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
    assign cd_base[55-gi] = key[64-PC1[gi]];
  end

  always_comb begin
    sel_valid = (key_cnt >= KCNT_FIRST) && (key_cnt <= KCNT_LAST);
    // Out-of-range selects still index a legal entry; the result is masked below.
    rot_amt   = ROT_AMT[4'(key_cnt - KCNT_FIRST)];
    cd_rot    = {rotl28(cd_base[55:28], rot_amt), rotl28(cd_base[27:0], rot_amt)};
  end

  // PC-2: pick 48 of the 56 rotated bits.
  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign pc2_out[47-gi] = cd_rot[56-PC2[gi]];
  end

  assign round_key = sel_valid ? pc2_out : '0;

  // Parity bits and the eight C/D bits skipped by PC-2 are intentionally unused.
  assign keygen_unused = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0], cd_rot};

endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencer for the DES round datapath.
//   Accepts one key/job in IDLE, runs 16 rounds stepping key_cnt through the
//   keygen selects (2->17 encrypt, 17->2 decrypt), then holds out_valid until
//   out_ready. abort flushes the job; rst_n resets asynchronously.
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     job handshake; in_decrypt/in_key sampled at accept
//   abort                 synchronous flush of the current job
//   dp_load/dp_round_en/dp_last/round_idx   datapath strobes
//   key_cnt/round_key     keygen select and resulting round key
//   out_valid/out_ready   result handshake
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int KEY_W = 64,
  parameter int CNT_W = 5,
  parameter int RK_W  = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [KEY_W-1:0] in_key,
  input  logic             abort,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic             dp_last,
  output logic [3:0]       round_idx,
  output logic [CNT_W-1:0] key_cnt,
  output logic [RK_W-1:0]  round_key,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               dec_q, dec_d;
  logic [CNT_W-1:0]   key_cnt_q, key_cnt_d;
  logic [3:0]         round_idx_q, round_idx_d;
  logic               round_en_q, round_en_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;

  // abort in IDLE blocks the accept but does not drop in_ready.
  assign in_ready = (state_q == IDLE);
  assign accept   = in_ready && in_valid && !abort;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    dec_d       = dec_q;
    key_cnt_d   = key_cnt_q;
    round_idx_d = round_idx_q;
    round_en_d  = round_en_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ROUND;
          key_d       = in_key;
          dec_d       = in_decrypt;
          key_cnt_d   = in_decrypt ? CNT_W'(KCNT_LAST) : CNT_W'(KCNT_FIRST);
          round_idx_d = 4'd0;
          round_en_d  = 1'b1;
          last_d      = 1'b0;
        end
      end
      ROUND: begin
        // abort wins over round completion; both leave key_cnt at its idle value.
        if (abort || (round_idx_q == 4'(NUM_ROUNDS - 1))) begin
          state_d     = abort ? IDLE : DONE;
          out_valid_d = !abort;
          key_cnt_d   = CNT_W'(KCNT_IDLE);
          round_idx_d = 4'd0;
          round_en_d  = 1'b0;
          last_d      = 1'b0;
        end else begin
          round_idx_d = round_idx_q + 4'd1;
          key_cnt_d   = dec_q ? key_cnt_q - CNT_W'(1) : key_cnt_q + CNT_W'(1);
          last_d      = (round_idx_q == 4'(NUM_ROUNDS - 2));
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        key_cnt_d   = CNT_W'(KCNT_IDLE);
        round_idx_d = 4'd0;
        round_en_d  = 1'b0;
        last_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      dec_q       <= 1'b0;
      key_cnt_q   <= CNT_W'(KCNT_IDLE);
      round_idx_q <= 4'd0;
      round_en_q  <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
      key_cnt_q   <= key_cnt_d;
      round_idx_q <= round_idx_d;
      round_en_q  <= round_en_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dp_load     = accept;
  assign dp_round_en = round_en_q;
  assign dp_last     = last_q;
  assign round_idx   = round_idx_q;
  assign key_cnt     = key_cnt_q;
  assign out_valid   = out_valid_q;

  des_round_ctrl_keygen u_keygen (
    .key       (key_q),
    .key_cnt   (key_cnt_q),
    .round_key (round_key)
  );

endmodule

// File: tb/tb_des_round_ctrl.sv
// Testbench for des_round_ctrl. A job-level reference model (round counter
// per job, iterative DES key schedule) predicts every output each cycle.
module tb_des_round_ctrl;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] RK_1  = 48'h1B02EFFC7072;
  localparam logic [47:0] RK_16 = 48'hCB3D8B0E17F5;

  localparam int REF_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int REF_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int REF_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct packed {
    logic        in_ready;
    logic        dp_load;
    logic        dp_round_en;
    logic        dp_last;
    logic [3:0]  round_idx;
    logic [4:0]  key_cnt;
    logic [47:0] round_key;
    logic        out_valid;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [63:0] in_key;
  logic        abort;
  logic        dp_load;
  logic        dp_round_en;
  logic        dp_last;
  logic [3:0]  round_idx;
  logic [4:0]  key_cnt;
  logic [47:0] round_key;
  logic        out_valid;
  logic        out_ready;
  obs_t        obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: m_job = -1 idle, 0..15 round in progress, 16 result waiting.
  int          m_job = -1;
  logic [63:0] m_key = '0;
  logic        m_dec = 1'b0;

  des_round_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_decrypt  (in_decrypt),
    .in_key      (in_key),
    .abort       (abort),
    .dp_load     (dp_load),
    .dp_round_en (dp_round_en),
    .dp_last     (dp_last),
    .round_idx   (round_idx),
    .key_cnt     (key_cnt),
    .round_key   (round_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  assign obs = {in_ready, dp_load, dp_round_en, dp_last, round_idx, key_cnt, round_key, out_valid};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Textbook key schedule: shift C and D round by round, then PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int round);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] rk;
    for (int j = 0; j < 56; j++) cd[55-j] = key[64-REF_PC1[j]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < round; r++) begin
      for (int s = 0; s < REF_SHIFT[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    cd = {c, d};
    for (int j = 0; j < 48; j++) rk[47-j] = cd[56-REF_PC2[j]];
    return rk;
  endfunction

  function automatic obs_t model_exp();
    obs_t e;
    e = '0;
    e.in_ready  = (m_job < 0);
    e.dp_load   = (m_job < 0) && in_valid && !abort;
    if (m_job >= 0 && m_job < 16) begin
      e.dp_round_en = 1'b1;
      e.dp_last     = (m_job == 15);
      e.round_idx   = 4'(m_job);
      e.key_cnt     = m_dec ? 5'(17 - m_job) : 5'(2 + m_job);
      e.round_key   = ref_subkey(m_key, m_dec ? 16 - m_job : m_job + 1);
    end
    e.out_valid = (m_job == 16);
    return e;
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_job = -1;
      m_key = '0;
      m_dec = 1'b0;
    end else if (m_job < 0) begin
      if (in_valid && !abort) begin
        m_job = 0;
        m_key = in_key;
        m_dec = in_decrypt;
      end
    end else if (abort) begin
      m_job = -1;
    end else if (m_job < 16) begin
      m_job++;
    end else if (out_ready) begin
      m_job = -1;
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_key = '0;
    abort = 1'b0; out_ready = 1'b0;
    m_job = -1; m_key = '0; m_dec = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = model_exp();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %p expected %p", obs, e);
    end
    n_checks++;
    if (in_ready !== 1'b1 || key_cnt !== 5'd0 || round_key !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_idle: in_ready=%b key_cnt=%0d rk=%h expected 1/0/0", in_ready, key_cnt, round_key);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_encrypt();
    obs_t e;
    for (int i = 0; i < 19; i++) begin
      in_valid = (i == 0); in_decrypt = 1'b0; abort = 1'b0;
      in_key = (i == 0) ? KEY_A : {$urandom, $urandom};
      out_ready = (i >= 17);
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL enc_cycle%0d: got %p expected %p", i, obs, e);
      end
      if (i == 1) begin
        n_checks++;
        if (round_key !== RK_1 || key_cnt !== 5'd2 || dp_round_en !== 1'b1) begin
          n_fail++;
          $display("FAIL enc_first: rk=%h kc=%0d en=%b expected %h/2/1", round_key, key_cnt, dp_round_en, RK_1);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (round_key !== RK_16 || key_cnt !== 5'd17 || dp_last !== 1'b1) begin
          n_fail++;
          $display("FAIL enc_last: rk=%h kc=%0d last=%b expected %h/17/1", round_key, key_cnt, dp_last, RK_16);
        end
      end
      if (i == 17) begin
        n_checks++;
        if (out_valid !== 1'b1 || dp_round_en !== 1'b0) begin
          n_fail++;
          $display("FAIL enc_latency: out_valid=%b en=%b expected 1/0", out_valid, dp_round_en);
        end
      end
      tick();
    end
  endtask

  task automatic test_decrypt();
    obs_t e;
    for (int i = 0; i < 19; i++) begin
      in_valid = (i == 0); in_decrypt = 1'b1; abort = 1'b0;
      in_key = KEY_A; out_ready = (i >= 17);
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL dec_cycle%0d: got %p expected %p", i, obs, e);
      end
      if (i == 1) begin
        n_checks++;
        if (round_key !== RK_16 || key_cnt !== 5'd17) begin
          n_fail++;
          $display("FAIL dec_first: rk=%h kc=%0d expected %h/17", round_key, key_cnt, RK_16);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (round_key !== RK_1 || key_cnt !== 5'd2 || dp_last !== 1'b1) begin
          n_fail++;
          $display("FAIL dec_last: rk=%h kc=%0d last=%b expected %h/2/1", round_key, key_cnt, dp_last, RK_1);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    obs_t e;
    for (int i = 0; i < 24; i++) begin
      in_valid = (i == 0) || (i >= 17 && i <= 21);
      in_decrypt = $urandom_range(0, 1); in_key = {$urandom, $urandom};
      abort = 1'b0; out_ready = (i == 22);
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got %p expected %p", i, obs, e);
      end
      if (i >= 17 && i <= 21) begin
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || dp_load !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold%0d: ov=%b ir=%b load=%b expected 1/0/0", i, out_valid, in_ready, dp_load);
        end
      end
      if (i == 23) begin
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_release: ir=%b ov=%b expected 1/0", in_ready, out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    obs_t e;
    int ov_seen;
    ov_seen = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = (i == 0) || (i == 9); in_decrypt = $urandom_range(0, 1);
      in_key = {$urandom, $urandom};
      abort = (i == 7) || (i == 9); out_ready = 1'b1;
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL abort_cycle%0d: got %p expected %p", i, obs, e);
      end
      if (i == 7) begin
        n_checks++;
        if (round_idx !== 4'd6) begin
          n_fail++;
          $display("FAIL abort_at: round_idx=%0d expected 6", round_idx);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (key_cnt !== 5'd0 || round_key !== 48'd0 || in_ready !== 1'b1 || dp_round_en !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_flush: kc=%0d rk=%h ir=%b en=%b expected 0/0/1/0", key_cnt, round_key, in_ready, dp_round_en);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (dp_load !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_idle_block: dp_load=%b expected 0", dp_load);
        end
      end
      if (out_valid === 1'b1) ov_seen++;
      tick();
    end
    n_checks++;
    if (ov_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid seen %0d cycles expected 0", ov_seen);
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 0); in_decrypt = 1'b0; in_key = {$urandom, $urandom};
      abort = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL arst_pre%0d: got %p expected %p", i, obs, e);
      end
      if (i < 5) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    m_job = -1; m_key = '0; m_dec = 1'b0;
    n_checks++;
    if (dp_round_en !== 1'b0 || key_cnt !== 5'd0 || round_idx !== 4'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_immediate: en=%b kc=%0d idx=%0d ir=%b expected 0/0/0/1", dp_round_en, key_cnt, round_idx, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      in_valid = (i == 0); in_decrypt = 1'b0; in_key = KEY_A;
      abort = 1'b0; out_ready = (i >= 17);
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL arst_post%0d: got %p expected %p", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_ignore_in_round();
    obs_t e;
    logic [63:0] k1;
    logic        d1;
    k1 = {$urandom, $urandom};
    d1 = $urandom_range(0, 1);
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1;
      in_key = (i == 0) ? k1 : {$urandom, $urandom};
      in_decrypt = (i == 0) ? d1 : !d1;
      abort = 1'b0; out_ready = (i == 17);
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ign_cycle%0d: got %p expected %p", i, obs, e);
      end
      if (i == 16) begin
        n_checks++;
        if (round_key !== ref_subkey(k1, d1 ? 1 : 16)) begin
          n_fail++;
          $display("FAIL ign_key_stable: rk=%h expected %h", round_key, ref_subkey(k1, d1 ? 1 : 16));
        end
      end
      if (i == 18) in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    obs_t e;
    for (int i = 0; i < 800; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_decrypt = $urandom_range(0, 1);
      in_key     = {$urandom, $urandom};
      abort      = ($urandom_range(0, 39) == 0);
      out_ready  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      e = model_exp();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %p expected %p", i, obs, e);
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_ignore_in_round();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
